// File: rtl/fifo_pll_serializer.sv
// -----------------------------------------------------------------------------
// fifo_pll_serializer
//
// Drain stage for the PLL sample FIFO. It pops one word at a time and shifts it
// out serially at a programmable bit rate. A frame marker covers the first bit
// of every word, and a fixed idle gap follows each word.
//
// Parameters
//   WIDTH      word width (FIFO data width)
//   DIV_WIDTH  width of clk_div; one bit period is clk_div+1 clk cycles
//   GAP_BITS   idle bit periods after each word (>= 1)
//   MSB_FIRST  1: MSB shifted first, 0: LSB shifted first
//
// Ports
//   clk           clock
//   rst           asynchronous, active-low reset
//   enable        allows new words to be fetched
//   clk_div       bit-period divider; sampled only when a word is loaded
//   fifo_empty    FIFO empty flag
//   fifo_rd_data  FIFO read data; valid the cycle after fifo_rd_en
//   fifo_rd_en    one-cycle pop request (registered)
//   ser_data      serial data; idles at 1
//   ser_strobe    pulse on the first cycle of every data bit
//   frame_sync    high for the whole first bit period of each word
//   busy          high whenever the engine is not idle
//   underrun_cnt  saturating count of words that were wanted but not available
// -----------------------------------------------------------------------------
module fifo_pll_serializer #(
  parameter int WIDTH     = 16,
  parameter int DIV_WIDTH = 8,
  parameter int GAP_BITS  = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] clk_div,
  input  logic                 fifo_empty,
  input  logic [WIDTH-1:0]     fifo_rd_data,
  output logic                 fifo_rd_en,
  output logic                 ser_data,
  output logic                 ser_strobe,
  output logic                 frame_sync,
  output logic                 busy,
  output logic [15:0]          underrun_cnt
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [GW-1:0] LAST_GAP = GW'(GAP_BITS - 1);
  localparam bit MSBF = (MSB_FIRST != 0);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t               state, state_n;
  logic [WIDTH-1:0]     shreg, shreg_n, shreg_adv;
  logic [DIV_WIDTH-1:0] div_q, div_q_n;
  logic [DIV_WIDTH-1:0] div_cnt, div_cnt_n;
  logic [BW-1:0]        bit_cnt, bit_cnt_n;
  logic [GW-1:0]        gap_cnt, gap_cnt_n;
  logic                 rd_en_n, ser_n, strobe_n, frame_n, busy_n;
  logic [15:0]          cnt_n;
  logic                 can_fetch;
  logic                 period_end;

  // Every output is a flop loaded from the next-state logic, so the visible
  // value in a cycle always belongs to the state occupied in that cycle.
  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    div_q_n    = div_q;
    div_cnt_n  = div_cnt;
    bit_cnt_n  = bit_cnt;
    gap_cnt_n  = gap_cnt;
    rd_en_n    = 1'b0;
    ser_n      = ser_data;
    strobe_n   = 1'b0;
    frame_n    = frame_sync;
    cnt_n      = underrun_cnt;
    can_fetch  = enable && !fifo_empty;
    period_end = (div_cnt == div_q);
    shreg_adv  = MSBF ? (shreg << 1) : (shreg >> 1);

    unique case (state)
      ST_IDLE: begin
        ser_n   = 1'b1;
        frame_n = 1'b0;
        if (can_fetch) begin
          state_n = ST_REQ;
          rd_en_n = 1'b1;
        end
      end

      ST_REQ: begin
        state_n = ST_WAIT;
      end

      ST_WAIT: begin
        // Read data is valid now; the first bit goes out on the next cycle.
        shreg_n   = fifo_rd_data;
        div_q_n   = clk_div;
        div_cnt_n = '0;
        bit_cnt_n = LAST_BIT;
        ser_n     = MSBF ? fifo_rd_data[WIDTH-1] : fifo_rd_data[0];
        strobe_n  = 1'b1;
        frame_n   = 1'b1;
        state_n   = ST_SHIFT;
      end

      ST_SHIFT: begin
        if (period_end) begin
          div_cnt_n = '0;
          frame_n   = 1'b0;
          if (bit_cnt == '0) begin
            state_n   = ST_GAP;
            ser_n     = 1'b1;
            gap_cnt_n = LAST_GAP;
          end else begin
            bit_cnt_n = bit_cnt - BW'(1);
            shreg_n   = shreg_adv;
            ser_n     = MSBF ? shreg_adv[WIDTH-1] : shreg_adv[0];
            strobe_n  = 1'b1;
          end
        end else begin
          div_cnt_n = div_cnt + DIV_WIDTH'(1);
        end
      end

      ST_GAP: begin
        if (period_end) begin
          div_cnt_n = '0;
          if (gap_cnt == '0) begin
            if (can_fetch) begin
              state_n = ST_REQ;
              rd_en_n = 1'b1;
            end else begin
              state_n = ST_IDLE;
              // Only a starved-but-enabled link counts as an underrun.
              if (enable && underrun_cnt != 16'hFFFF)
                cnt_n = underrun_cnt + 16'd1;
            end
          end else begin
            gap_cnt_n = gap_cnt - GW'(1);
          end
        end else begin
          div_cnt_n = div_cnt + DIV_WIDTH'(1);
        end
      end

      default: begin
        state_n = ST_IDLE;
        ser_n   = 1'b1;
        frame_n = 1'b0;
      end
    endcase

    busy_n = (state_n != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      shreg        <= '0;
      div_q        <= '0;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      gap_cnt      <= '0;
      fifo_rd_en   <= 1'b0;
      ser_data     <= 1'b1;
      ser_strobe   <= 1'b0;
      frame_sync   <= 1'b0;
      busy         <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      state        <= state_n;
      shreg        <= shreg_n;
      div_q        <= div_q_n;
      div_cnt      <= div_cnt_n;
      bit_cnt      <= bit_cnt_n;
      gap_cnt      <= gap_cnt_n;
      fifo_rd_en   <= rd_en_n;
      ser_data     <= ser_n;
      ser_strobe   <= strobe_n;
      frame_sync   <= frame_n;
      busy         <= busy_n;
      underrun_cnt <= cnt_n;
    end
  end

endmodule

// File: tb/tb_fifo_pll_serializer.sv
// -----------------------------------------------------------------------------
// tb_fifo_pll_serializer
//
// Bench for fifo_pll_serializer. A small FIFO emulation feeds the design.
// A timeline model predicts every output from the word start cycle and the
// latched divisor. Directed scenarios add literal expectations on top.
// -----------------------------------------------------------------------------
module tb_fifo_pll_serializer;

  localparam int WIDTH     = 16;
  localparam int DIV_WIDTH = 8;
  localparam int GAP_BITS  = 2;
  localparam int MSB_FIRST = 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 enable = 1'b0;
  logic [DIV_WIDTH-1:0] clk_div = '0;
  logic                 fifo_empty = 1'b1;
  logic [WIDTH-1:0]     fifo_rd_data = 16'hDEAD;
  logic                 fifo_rd_en, ser_data, ser_strobe, frame_sync, busy;
  logic [15:0]          underrun_cnt;

  fifo_pll_serializer #(
    .WIDTH(WIDTH), .DIV_WIDTH(DIV_WIDTH), .GAP_BITS(GAP_BITS), .MSB_FIRST(MSB_FIRST)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .clk_div(clk_div),
    .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en(fifo_rd_en), .ser_data(ser_data), .ser_strobe(ser_strobe),
    .frame_sync(frame_sync), .busy(busy), .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int fail_prints = 0;
  int rd_pulses = 0;

  logic [WIDTH-1:0] fq[$];
  logic [WIDTH-1:0] mq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [WIDTH-1:0] w);
    fq.push_back(w);
    mq.push_back(w);
  endtask

  // FIFO emulation: data shows up one cycle after the pop request and is
  // garbage at all other times, so early or late sampling is visible.
  logic             pend = 1'b0;
  logic [WIDTH-1:0] pend_word = '0;
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (pend) begin
        fifo_rd_data = pend_word;
        pend = 1'b0;
      end else begin
        fifo_rd_data = 16'hDEAD;
      end
      if (fifo_rd_en) begin
        if (fq.size() > 0) begin
          pend_word = fq.pop_front();
          pend = 1'b1;
        end else begin
          total++;
          bad++;
          $display("FAIL pop_while_empty: got rd_en=1 expected 0 at %0t", $time);
        end
      end
      fifo_empty = (fq.size() == 0);
    end
  end

  // Timeline model: a word fetched at edge t0 has rd_en in cycle t0, its data
  // bits in cycles t0+2 .. t0+1+WIDTH*D and the decision edge at
  // t0+2+(WIDTH+GAP_BITS)*D, where D is clk_div+1 seen at edge t0+1.
  int               cyc = 0;
  int               m_t0 = 0;
  int               m_d = 1;
  int               k, j, b;
  bit               m_active = 1'b0;
  logic [WIDTH-1:0] m_w = '0;
  logic             e_rd = 1'b0, e_ser = 1'b1, e_stb = 1'b0, e_frm = 1'b0, e_busy = 1'b0;
  logic [15:0]      e_cnt = '0;

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_active = 1'b0;
        e_cnt = '0;
        e_rd = 1'b0; e_ser = 1'b1; e_stb = 1'b0; e_frm = 1'b0; e_busy = 1'b0;
      end else begin
        cyc++;
        if (m_active && cyc == m_t0 + 1) m_d = int'(clk_div) + 1;
        if (m_active && cyc == m_t0 + 2 + (WIDTH + GAP_BITS) * m_d) begin
          m_active = 1'b0;
          if (enable && mq.size() == 0)
            e_cnt = (e_cnt == 16'hFFFF) ? e_cnt : e_cnt + 16'd1;
        end
        if (!m_active && enable && mq.size() > 0) begin
          m_active = 1'b1;
          m_t0 = cyc;
          m_w = mq.pop_front();
        end
        k = cyc - m_t0;
        e_rd = m_active && (k == 0);
        e_busy = m_active;
        e_ser = 1'b1; e_stb = 1'b0; e_frm = 1'b0;
        if (m_active && k >= 2 && k < 2 + WIDTH * m_d) begin
          j = k - 2;
          b = j / m_d;
          e_ser = (MSB_FIRST != 0) ? m_w[WIDTH-1-b] : m_w[b];
          e_stb = (j % m_d) == 0;
          e_frm = (b == 0);
        end
      end
    end
  end

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (fail_prints < 40)
        $display("FAIL cmp_%s cycle %0d: dut=%h model=%h", name, cyc, act, exp);
      fail_prints++;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cmp("rd_en",    16'(fifo_rd_en),   16'(e_rd));
      cmp("ser_data", 16'(ser_data),     16'(e_ser));
      cmp("strobe",   16'(ser_strobe),   16'(e_stb));
      cmp("frame",    16'(frame_sync),   16'(e_frm));
      cmp("busy",     16'(busy),         16'(e_busy));
      cmp("underrun", underrun_cnt,      e_cnt);
      if (fifo_rd_en) rd_pulses++;
    end
  end

  logic [255:0] cap_ser, cap_stb, cap_frm, cap_rd;

  task automatic cap_clear();
    cap_ser = '0; cap_stb = '0; cap_frm = '0; cap_rd = '0;
  endtask

  task automatic capture(input int from, input int n);
    for (int i = from; i < from + n; i++) begin
      @(negedge clk);
      cap_ser[i] = ser_data;
      cap_stb[i] = ser_strobe;
      cap_frm[i] = frame_sync;
      cap_rd[i]  = fifo_rd_en;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rd_en"},  64'(fifo_rd_en),   64'(0));
    check({tag, "_ser"},    64'(ser_data),     64'(1));
    check({tag, "_strobe"}, 64'(ser_strobe),   64'(0));
    check({tag, "_frame"},  64'(frame_sync),   64'(0));
    check({tag, "_busy"},   64'(busy),         64'(0));
    check({tag, "_cnt"},    64'(underrun_cnt), 64'(0));
  endtask

  int base;

  initial begin
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b1;
    @(negedge clk);

    // 1: single word, one cycle per bit
    push(16'hA5C3);
    clk_div = 8'd0;
    enable = 1'b1;
    base = rd_pulses;
    @(negedge clk);
    check("t1_rd_en_pulse", 64'(fifo_rd_en), 64'(1));
    @(negedge clk);
    check("t1_rd_en_single", 64'(fifo_rd_en), 64'(0));
    enable = 1'b0;
    cap_clear();
    capture(0, 16);
    check("t1_ser_bits", 64'(cap_ser[15:0]), 64'(16'hC3A5));
    check("t1_frame",    64'(cap_frm[15:0]), 64'(16'h0001));
    check("t1_strobe",   64'(cap_stb[15:0]), 64'(16'hFFFF));
    repeat (3) @(negedge clk);
    check("t1_idle",     64'(busy), 64'(0));
    check("t1_pulses",   64'(rd_pulses - base), 64'(1));

    // 2: four cycles per bit; clk_div changed mid-word has no effect
    push(16'h8001);
    clk_div = 8'd3;
    enable = 1'b1;
    @(negedge clk);
    check("t2_rd_en_pulse", 64'(fifo_rd_en), 64'(1));
    @(negedge clk);
    enable = 1'b0;
    cap_clear();
    capture(0, 8);
    clk_div = 8'd0;
    capture(8, 56);
    check("t2_ser_line", 64'(cap_ser[63:0]), 64'h F000_0000_0000_000F);
    check("t2_strobe",   64'(cap_stb[63:0]), 64'h 1111_1111_1111_1111);
    check("t2_frame",    64'(cap_frm[63:0]), 64'h 0000_0000_0000_000F);
    check("t2_after",    64'(cap_ser[64]),   64'(0));
    repeat (9) @(negedge clk);
    check("t2_idle", 64'(busy), 64'(0));

    // 3: two back-to-back words, GAP_BITS idle plus REQ/WAIT between them
    push(16'h1234);
    push(16'hF00F);
    clk_div = 8'd0;
    enable = 1'b1;
    base = rd_pulses;
    @(negedge clk);
    check("t3_rd_en_pulse", 64'(fifo_rd_en), 64'(1));
    @(negedge clk);
    cap_clear();
    capture(0, 36);
    enable = 1'b0;
    check("t3_ser_line", 64'(cap_ser[35:0]), 64'(36'hF00FF2C48));
    check("t3_strobe",   64'(cap_stb[35:0]), 64'(36'hFFFF0FFFF));
    check("t3_frame",    64'(cap_frm[35:0]), 64'(36'h000100001));
    check("t3_rd_en",    64'(cap_rd[35:0]),  64'(36'h000040000));
    repeat (3) @(negedge clk);
    check("t3_pulses", 64'(rd_pulses - base), 64'(2));
    check("t3_idle",   64'(busy), 64'(0));
    check("t3_cnt",    64'(underrun_cnt), 64'(0));

    // 4: enable dropped during bit 5 with three words queued
    push(16'h0F0F);
    push(16'h1111);
    push(16'h2222);
    clk_div = 8'd1;
    enable = 1'b1;
    base = rd_pulses;
    @(negedge clk);
    @(negedge clk);
    repeat (11) @(negedge clk);
    check("t4_bit5", 64'(ser_data), 64'(1));
    enable = 1'b0;
    repeat (26) @(negedge clk);
    check("t4_idle", 64'(busy), 64'(0));
    repeat (5) @(negedge clk);
    check("t4_pulses",    64'(rd_pulses - base), 64'(1));
    check("t4_cnt",       64'(underrun_cnt), 64'(0));
    check("t4_fifo_left", 64'(fq.size()), 64'(2));

    // 6: reset during bit 8, then fetch resumes with the normal latency
    clk_div = 8'd0;
    enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    repeat (9) @(negedge clk);
    check("t6_bit8_before", 64'(ser_data), 64'(0));
    check("t6_busy_before", 64'(busy), 64'(1));
    @(posedge clk);
    #3 rst = 1'b0;
    #1 check_reset_values("t6_async");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    base = rd_pulses;
    @(negedge clk);
    check("t6_resume_rd_en", 64'(fifo_rd_en), 64'(1));

    // 5: enable held, FIFO runs dry after the word -> one underrun
    repeat (20) @(negedge clk);
    check("t5_cnt_one", 64'(underrun_cnt), 64'(1));
    check("t5_idle",    64'(busy), 64'(0));
    check("t6_pulses",  64'(rd_pulses - base), 64'(1));

    #2 force dut.underrun_cnt = 16'hFFFE;
    e_cnt = 16'hFFFE;
    #1 release dut.underrun_cnt;
    @(negedge clk);
    check("t5_preset", 64'(underrun_cnt), 64'(16'hFFFE));
    push(16'h3333);
    repeat (22) @(negedge clk);
    check("t5_cnt_max", 64'(underrun_cnt), 64'(16'hFFFF));
    push(16'h4444);
    repeat (22) @(negedge clk);
    check("t5_cnt_sat", 64'(underrun_cnt), 64'(16'hFFFF));

    @(posedge clk);
    #3 rst = 1'b0;
    #1 check("final_reset_cnt", 64'(underrun_cnt), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    enable = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
